// File: rtl/proc_timers_pkg.sv
// Shared constants for the periodic timer block: register map and the
// bit positions of the channel-configuration word written to ADDR_CFG.
package proc_timers_pkg;

  // Register map (2-bit word address)
  localparam logic [1:0] ADDR_CFG  = 2'd0;  // wr: configure channel, rd: ready flags
  localparam logic [1:0] ADDR_CLR  = 2'd1;  // wr: clear ready bits, rd: enable bits
  localparam logic [1:0] ADDR_MASK = 2'd2;  // irq mask (only with PROC_TIMERS_IRQ_EN)

  // Configuration word fields
  localparam int IDX_LSB = 16;
  localparam int IDX_MSB = 18;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int PER_LSB = 0;
  localparam int PER_MSB = 15;
  localparam int EN_BIT  = 24;

  // Channel index carried in a configuration word
  function automatic logic [IDX_W-1:0] cfg_index(input logic [31:0] word);
    return word[IDX_MSB:IDX_LSB];
  endfunction

  // Enable bit carried in a configuration word
  function automatic logic cfg_enable(input logic [31:0] word);
    return word[EN_BIT];
  endfunction

endpackage

// File: rtl/proc_timer_chan.sv
// One periodic timer channel: period register, down-counter, enable and a
// sticky ready flag. Counts ms ticks; on the tick that takes the counter
// past 1 it reloads the period and raises ready (visible the next cycle).
module proc_timer_chan
  import proc_timers_pkg::*;
#(
  parameter int period_width = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    cfg_wr,
  input  logic [period_width-1:0] cfg_period,
  input  logic                    cfg_en,
  input  logic                    clr,
  output logic                    ready,
  output logic                    en
);

  logic [period_width-1:0] period;
  logic [period_width-1:0] count;
  logic                    active;
  logic                    expire;

  // A channel only runs when enabled with a nonzero period; expiry is the
  // tick seen while the counter sits at 1 (0 is unreachable once running).
  always_comb begin
    active = tick && en && (period != '0);
    expire = active && (count <= period_width'(1));
  end

  // Channel state: config write beats a coincident tick, expiry beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= '0;
      count  <= '0;
      en     <= 1'b0;
      ready  <= 1'b0;
    end else if (cfg_wr) begin
      period <= cfg_period;
      count  <= cfg_period;
      en     <= cfg_en;
      ready  <= 1'b0;
    end else begin
      if (expire)
        count <= period;
      else if (active)
        count <= count - 1'b1;

      if (expire)
        ready <= 1'b1;
      else if (clr)
        ready <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_timers.sv
// Periodic timer block: num_timers auto-repeating millisecond timers behind
// a zero-wait-state register port. Optional feature macro
// PROC_TIMERS_IRQ_EN adds an irq mask register at ADDR_MASK and a
// registered interrupt; without it irq is tied low and ADDR_MASK reads 0.
module proc_timers
  import proc_timers_pkg::*;
#(
  parameter int num_timers   = 8,
  parameter int period_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic                  we,
  input  logic [1:0]            addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ack,
  input  logic                  ms_tick,
  output logic [num_timers-1:0] ready,
  output logic                  irq
);

  logic                    wr;
  logic                    cfg_wr;
  logic [IDX_W-1:0]        cfg_idx;
  logic [period_width-1:0] cfg_period;
  logic                    cfg_en;
  logic [num_timers-1:0]   clr_vec;
  logic [num_timers-1:0]   en;

  // Every bus access completes in the strobe cycle
  assign ack = stb;

  // Write decode; an index outside 0..num_timers-1 matches no channel
  always_comb begin
    wr         = stb && we;
    cfg_wr     = wr && (addr == ADDR_CFG);
    cfg_idx    = cfg_index(data_in);
    cfg_period = data_in[PER_LSB +: period_width];
    cfg_en     = cfg_enable(data_in);
    clr_vec    = (wr && (addr == ADDR_CLR)) ? data_in[num_timers-1:0] : '0;
  end

  // Not every data_in bit is a register field
  logic unused_data;
  assign unused_data = ^data_in;

  genvar i;
  generate
    for (i = 0; i < num_timers; i++) begin : g_chan
      proc_timer_chan #(
        .period_width(period_width)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .tick      (ms_tick),
        .cfg_wr    (cfg_wr && (cfg_idx == IDX_W'(i))),
        .cfg_period(cfg_period),
        .cfg_en    (cfg_en),
        .clr       (clr_vec[i]),
        .ready     (ready[i]),
        .en        (en[i])
      );
    end
  endgenerate

`ifdef PROC_TIMERS_IRQ_EN
  logic [num_timers-1:0] irq_mask;
  logic                  irq_q;

  // Mask register and interrupt, the latter lagging ready by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && (addr == ADDR_MASK))
        irq_mask <= data_in[num_timers-1:0];
      irq_q <= |(ready & irq_mask);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux; the bus is driven with zeros outside read cycles
  always_comb begin
    data_out = '0;
    if (stb && !we) begin
      case (addr)
        ADDR_CFG:  data_out[num_timers-1:0] = ready;
        ADDR_CLR:  data_out[num_timers-1:0] = en;
`ifdef PROC_TIMERS_IRQ_EN
        ADDR_MASK: data_out[num_timers-1:0] = irq_mask;
`endif
        default:   data_out = '0;
      endcase
    end
  end

endmodule
